mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer beside the single-cycle execute units.
//  - Accepts one MUL/MULHU/DIVU/REMU op per issue from ID.
//  - Runs one radix-2 step per cycle and presents the result to WB.
//  - Holds ID via stall_o while busy. Uses the same v/stall handshake as the execute stage.
// PARAMETERS
//  WORD    32                    datapath width (bits)
//  W_RD    5                     destination register number width
//  CNT_W   $clog2(WORD)+1        iteration counter width
// PORTS
//  clk        in   1       clock (single domain)
//  rst        in   1       reset: synchronous, active-high
//  v_i        in   1       ID: op valid
//  stall_o    out  1       ID: cannot accept this cycle
//  op_i       in   2       00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//  dest_i     in   WORD    operand A (multiplicand / dividend)
//  src_i      in   WORD    operand B (multiplier / divisor)
//  rd_num_i   in   W_RD    destination register
//  wb_i       in   1       writeback enable
//  stall_i    in   1       WB: cannot take result this cycle
//  v_o        out  1       WB: result valid
//  rd_num_o   out  W_RD    latched rd_num_i
//  wb_o       out  1       latched wb_i
//  rd_data_o  out  WORD    result
//  busy_o     out  1       state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - State goes to IDLE. v_o, rd_num_o, wb_o, rd_data_o and busy_o become 0; stall_o is 0.
//   - Applies in any state; an in-flight op is discarded and never produces v_o.
//  FSM: IDLE -> BUSY -> DONE -> (IDLE | BUSY).
//  IDLE
//   - stall_o=0.
//   - v_i=1: latch op, A, B, rd_num, wb; cnt<=WORD; go to BUSY.
//  BUSY
//   - stall_o=1, v_o=0.
//   - One iteration per cycle, cnt decrements.
//   - Iteration with cnt==1 completes: load rd_data_o and go to DONE.
//  DONE
//   - v_o=1, stall_o=stall_i.
//   - rd_data_o, rd_num_o and wb_o are held stable while stall_i=1.
//   - stall_i=0 and v_i=1: new op accepted the same cycle, go to BUSY (v_o=0 the next cycle).
//   - stall_i=0 and v_i=0: go to IDLE.
//  Latency: op accepted at edge N gives v_o=1 from edge N+WORD+1 (33 cycles for WORD=32).
//  Multiply
//   - 2*WORD product register P accumulates the shifted A register when B[0]=1.
//   - A shifts left and B shifts right each iteration.
//   - MUL returns P[WORD-1:0]; MULHU returns P[2*WORD-1:WORD]. Unsigned.
//  Divide
//   - Restoring, unsigned.
//   - Divisor 0 needs no special case: the algorithm naturally gives DIVU=all ones, REMU=A.
//  op_i is ignored unless the op is accepted. v_i is ignored while in BUSY.
// CONFIGURATION
//  MDU_EARLY_OUT_EN
//   - Defined: MUL/MULHU leave BUSY once the remaining multiplier bits are 0, after at
//     least 1 iteration.
//   - Iterations = max(1, bit-length(B)); v_o at N+iterations+1. Divide is unchanged.
//   - Undefined: fixed WORD iterations for every op.
// STRUCTURE
//  Shared package / params include:
//   - Op encodings MDU_MUL/MDU_MULHU/MDU_DIVU/MDU_REMU.
//   - FSM state constants S_IDLE/S_BUSY/S_DONE.
//   - WORD and W_RD.
//  Sub-module mdu_step: combinational single iteration.
//   - Inputs: op, P, A, B, remainder/quotient registers.
//   - Outputs: next register values.
//  The top level holds the FSM, counter, latched tags and the handshake.
// TESTING (WORD=32)
//  1. MUL A=7, B=6 -> stall_o=1 for 32 cycles; v_o at N+33; rd_data_o=42.
//  2. A=B=0xFFFFFFFF: MUL -> 0x00000001; MULHU -> 0xFFFFFFFE.
//  3. A=100, B=7: DIVU -> 14, REMU -> 2. A=5, B=0: DIVU -> 0xFFFFFFFF, REMU -> 5.
//  4. Hold stall_i=1 for 5 cycles in DONE -> v_o, rd_data_o and rd_num_o stable, stall_o=1.
//     Release with v_i=1 -> new op accepted; v_o=0 the next cycle.
//  5. rst=1 at BUSY iteration 10 -> next cycle all outputs 0, busy_o=0; no v_o afterwards.
//  6. MDU_EARLY_OUT_EN defined: MUL A=1234, B=3 -> v_o at N+3, result 3702.
//     B=0 -> v_o at N+2, result 0. Undefined: both take N+33.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared constants and types for the iterative multiply/divide sequencer.
package mdu_seq_pkg;

    localparam int WORD  = 32;
    localparam int W_RD  = 5;
    localparam int CNT_W = $clog2(WORD) + 1;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } mdu_state_e;

    function automatic logic is_mul(input mdu_op_e op);
        return !op[1];
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// ID-issue and WB-result handshake of the multiply/divide sequencer.
interface mdu_seq_if;
    import mdu_seq_pkg::*;

    logic                v_i;
    logic                stall_o;
    mdu_op_e             op_i;
    logic [WORD-1:0]     dest_i;
    logic [WORD-1:0]     src_i;
    logic [W_RD-1:0]     rd_num_i;
    logic                wb_i;
    logic                stall_i;
    logic                v_o;
    logic [W_RD-1:0]     rd_num_o;
    logic                wb_o;
    logic [WORD-1:0]     rd_data_o;
    logic                busy_o;

    modport master (
        output v_i, op_i, dest_i, src_i, rd_num_i, wb_i, stall_i,
        input  stall_o, v_o, rd_num_o, wb_o, rd_data_o, busy_o
    );

    modport slave (
        input  v_i, op_i, dest_i, src_i, rd_num_i, wb_i, stall_i,
        output stall_o, v_o, rd_num_o, wb_o, rd_data_o, busy_o
    );

endinterface

// File: rtl/mdu_seq_step.sv
// mdu_step: one combinational radix-2 iteration (shift-add multiply or restoring divide).
module mdu_step
    import mdu_seq_pkg::*;
(
    input  mdu_op_e           op_i,
    input  logic [2*WORD-1:0] p_i,
    input  logic [2*WORD-1:0] a_i,
    input  logic [WORD-1:0]   b_i,
    input  logic [WORD-1:0]   rem_i,
    input  logic [WORD-1:0]   quo_i,
    output logic [2*WORD-1:0] p_o,
    output logic [2*WORD-1:0] a_o,
    output logic [WORD-1:0]   b_o,
    output logic [WORD-1:0]   rem_o,
    output logic [WORD-1:0]   quo_o
);

    logic [WORD:0] shifted;
    logic [WORD:0] diff;

    always_comb begin
        p_o     = p_i;
        a_o     = a_i;
        b_o     = b_i;
        rem_o   = rem_i;
        quo_o   = quo_i;
        shifted = {rem_i, quo_i[WORD-1]};
        diff    = shifted - {1'b0, b_i};
        if (is_mul(op_i)) begin
            if (b_i[0]) p_o = p_i + a_i;
            a_o = a_i << 1;
            b_o = b_i >> 1;
        end else begin
            // A zero divisor never borrows, which yields all-ones quotient and remainder = A.
            if (!diff[WORD]) begin
                rem_o = diff[WORD-1:0];
                quo_o = {quo_i[WORD-2:0], 1'b1};
            end else begin
                rem_o = shifted[WORD-1:0];
                quo_o = {quo_i[WORD-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer with v/stall handshake to ID and WB.
// Optional `MDU_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mdu_seq
    import mdu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mdu_seq_if.slave   bus
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD-1:0]   rd_data_q, rd_data_d;
    logic [W_RD-1:0]   rd_num_q, rd_num_d;
    logic              wb_q, wb_d;

    mdu_op_e           op_q;
    logic [2*WORD-1:0] p_q, a_q, p_n, a_n;
    logic [WORD-1:0]   b_q, rem_q, quo_q, b_n, rem_n, quo_n;
    logic [WORD-1:0]   result;
    logic              stall, accept, last;

    mdu_step u_step (
        .op_i  (op_q),
        .p_i   (p_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .rem_i (rem_q),
        .quo_i (quo_q),
        .p_o   (p_n),
        .a_o   (a_n),
        .b_o   (b_n),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    always_comb begin
        case (state_q)
            S_BUSY:  stall = 1'b1;
            S_DONE:  stall = bus.stall_i;
            default: stall = 1'b0;
        endcase
        accept = bus.v_i && !stall;
    end

`ifdef MDU_EARLY_OUT_EN
    assign last = (cnt_q == CNT_W'(1)) || (is_mul(op_q) && (b_n == '0));
`else
    assign last = (cnt_q == CNT_W'(1));
`endif

    always_comb begin
        case (op_q)
            MDU_MUL:   result = p_n[WORD-1:0];
            MDU_MULHU: result = p_n[2*WORD-1:WORD];
            MDU_DIVU:  result = quo_n;
            default:   result = rem_n;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        rd_num_d  = rd_num_q;
        wb_d      = wb_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d  = S_BUSY;
                    cnt_d    = CNT_W'(WORD);
                    rd_num_d = bus.rd_num_i;
                    wb_d     = bus.wb_i;
                end else if (state_q == S_DONE && !bus.stall_i) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    rd_data_d = result;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_num_q  <= '0;
            wb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rd_num_q  <= rd_num_d;
            wb_q      <= wb_d;
        end
    end

    // Datapath registers are always (re)loaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= bus.op_i;
            p_q   <= '0;
            a_q   <= {{WORD{1'b0}}, bus.dest_i};
            b_q   <= bus.src_i;
            rem_q <= '0;
            quo_q <= bus.dest_i;
        end else if (state_q == S_BUSY) begin
            p_q   <= p_n;
            a_q   <= a_n;
            b_q   <= b_n;
            rem_q <= rem_n;
            quo_q <= quo_n;
        end
    end

    assign bus.stall_o   = stall;
    assign bus.v_o       = (state_q == S_DONE);
    assign bus.busy_o    = (state_q != S_IDLE);
    assign bus.rd_data_o = rd_data_q;
    assign bus.rd_num_o  = rd_num_q;
    assign bus.wb_o      = wb_q;

endmodule
